// File: rtl/ysyx_22040750_lsu.sv
// ysyx_22040750_lsu
//  Load/store unit between the MEM stage and the data cache controller.
//  It holds one op at a time. For each op it raises one single-cycle read or
//  write request to the dcache, then waits for the completion. When the op is
//  a load, it shifts the returned doubleword down and sign- or zero-extends it.
//  It then returns one result beat to WB.
// Ports
//  I_clk, I_rst        clock, synchronous active-high reset
//  I_valid / O_ready   op handshake from EX (O_ready high only in IDLE)
//  I_addr, I_wdata, I_funct3, I_is_store, I_rd   op fields
//  O_valid, O_rdata, O_rd, O_err                 one-cycle result beat to WB
//  O_cpu_addr/data/wmask, O_cpu_rd_req/wr_req    dcache request side
//  I_cpu_mem_ready, I_cpu_data, I_cpu_rvalid, I_cpu_bvalid   dcache response side
module ysyx_22040750_lsu #(
  parameter int WAIT_LIMIT = 1024
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [31:0] I_addr,
  input  logic [63:0] I_wdata,
  input  logic [2:0]  I_funct3,
  input  logic        I_is_store,
  input  logic [4:0]  I_rd,
  output logic        O_valid,
  output logic [63:0] O_rdata,
  output logic [4:0]  O_rd,
  output logic        O_err,
  output logic [31:0] O_cpu_addr,
  output logic [63:0] O_cpu_data,
  output logic [7:0]  O_cpu_wmask,
  output logic        O_cpu_rd_req,
  output logic        O_cpu_wr_req,
  input  logic        I_cpu_mem_ready,
  input  logic [63:0] I_cpu_data,
  input  logic        I_cpu_rvalid,
  input  logic        I_cpu_bvalid
);

  localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, WAIT_W, DONE} state_t;

  state_t          state;
  logic [2:0]      funct3;
  logic            is_store;
  logic [CW-1:0]   count;
  logic            timeout;
  logic            bad_op;
  logic [7:0]      base_mask;

  // Illegal encodings and misaligned accesses never reach the dcache.
  always_comb begin
    bad_op = 1'b0;
    if (I_funct3 == 3'b111 || (I_is_store && I_funct3[2])) bad_op = 1'b1;
    unique case (I_funct3[1:0])
      2'b01:   if (I_addr[0])        bad_op = 1'b1;
      2'b10:   if (I_addr[1:0] != 0) bad_op = 1'b1;
      2'b11:   if (I_addr[2:0] != 0) bad_op = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (I_funct3[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0f;
      default: base_mask = 8'hff;
    endcase
  end

  assign timeout = (count == CW'(WAIT_LIMIT - 1));
  assign O_ready = (state == IDLE);

  // The request follows the dcache ready signal in the same cycle. This keeps
  // the issue cycle to exactly one cycle. When the timeout fires while the op
  // is still in ISSUE, the request is suppressed.
  assign O_cpu_rd_req = (state == ISSUE) && I_cpu_mem_ready && !timeout && !is_store;
  assign O_cpu_wr_req = (state == ISSUE) && I_cpu_mem_ready && !timeout &&  is_store;

  function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] off,
                                          input logic [2:0] f3);
    logic [63:0] x;
    x = d >> {off, 3'b000};
    unique case (f3)
      3'b000:  return {{56{x[7]}},  x[7:0]};
      3'b001:  return {{48{x[15]}}, x[15:0]};
      3'b010:  return {{32{x[31]}}, x[31:0]};
      3'b011:  return x;
      3'b100:  return {56'b0, x[7:0]};
      3'b101:  return {48'b0, x[15:0]};
      3'b110:  return {32'b0, x[31:0]};
      default: return 64'b0;
    endcase
  endfunction

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= IDLE;
      funct3      <= 3'b0;
      is_store    <= 1'b0;
      count       <= '0;
      O_valid     <= 1'b0;
      O_rdata     <= 64'b0;
      O_rd        <= 5'b0;
      O_err       <= 1'b0;
      O_cpu_addr  <= 32'b0;
      O_cpu_data  <= 64'b0;
      O_cpu_wmask <= 8'b0;
    end else begin
      O_valid <= 1'b0;
      unique case (state)
        IDLE: if (I_valid) begin
          funct3      <= I_funct3;
          is_store    <= I_is_store;
          count       <= '0;
          O_rd        <= I_is_store ? 5'b0 : I_rd;
          O_cpu_addr  <= I_addr;
          O_cpu_data  <= I_wdata << {I_addr[2:0], 3'b000};
          O_cpu_wmask <= base_mask << I_addr[2:0];
          if (bad_op) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b1;
            O_rdata <= 64'b0;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          count <= count + 1'b1;
          if (timeout) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b1;
          end else if (I_cpu_mem_ready) begin
            state <= is_store ? WAIT_W : WAIT_R;
          end
        end
        WAIT_R: begin
          count <= count + 1'b1;
          // A response that arrives in the timeout cycle still completes the op.
          if (I_cpu_rvalid) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b0;
            O_rdata <= extract(I_cpu_data, O_cpu_addr[2:0], funct3);
          end else if (timeout) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b1;
          end
        end
        WAIT_W: begin
          count <= count + 1'b1;
          // MMIO writes never send bvalid. Seeing ready again means the write was taken.
          if (I_cpu_bvalid || I_cpu_mem_ready) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b0;
          end else if (timeout) begin
            state   <= DONE;
            O_valid <= 1'b1;
            O_err   <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          O_err   <= 1'b0;
          O_rdata <= 64'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_lsu.sv
// Scoreboard bench for ysyx_22040750_lsu, built with WAIT_LIMIT=16.
// Every op pushes its expected result beat when it is driven. A monitor pops
// and compares that entry when O_valid fires. An inline dcache model answers
// the requests.
module tb_ysyx_22040750_lsu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_valid;
  logic        O_ready;
  logic [31:0] I_addr;
  logic [63:0] I_wdata;
  logic [2:0]  I_funct3;
  logic        I_is_store;
  logic [4:0]  I_rd;
  logic        O_valid;
  logic [63:0] O_rdata;
  logic [4:0]  O_rd;
  logic        O_err;
  logic [31:0] O_cpu_addr;
  logic [63:0] O_cpu_data;
  logic [7:0]  O_cpu_wmask;
  logic        O_cpu_rd_req;
  logic        O_cpu_wr_req;
  logic        I_cpu_mem_ready;
  logic [63:0] I_cpu_data;
  logic        I_cpu_rvalid;
  logic        I_cpu_bvalid;

  ysyx_22040750_lsu #(.WAIT_LIMIT(16)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .O_ready(O_ready),
    .I_addr(I_addr), .I_wdata(I_wdata), .I_funct3(I_funct3), .I_is_store(I_is_store),
    .I_rd(I_rd), .O_valid(O_valid), .O_rdata(O_rdata), .O_rd(O_rd), .O_err(O_err),
    .O_cpu_addr(O_cpu_addr), .O_cpu_data(O_cpu_data), .O_cpu_wmask(O_cpu_wmask),
    .O_cpu_rd_req(O_cpu_rd_req), .O_cpu_wr_req(O_cpu_wr_req),
    .I_cpu_mem_ready(I_cpu_mem_ready), .I_cpu_data(I_cpu_data),
    .I_cpu_rvalid(I_cpu_rvalid), .I_cpu_bvalid(I_cpu_bvalid)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result monitor: every O_valid beat must match the oldest expectation.
  always @(negedge I_clk) begin
    if (O_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", O_rdata, e.rdata);
        chk("err",   {63'b0, O_err}, {63'b0, e.err});
        chk("rd",    {59'b0, O_rd},  {59'b0, e.rd});
      end
    end
  end

  // Drive one op and play the dcache.
  //  ready_low: mem_ready is low for cycles 1..ready_low after accept.
  //  rdelay:    rvalid comes rdelay cycles after the read request (<0: never).
  //  e_lat:     exact cycles from accept to O_valid (<0: an error op, checked as 1..2).
  task automatic do_op(input logic [31:0] addr, input logic [63:0] wdata, input logic [2:0] f3,
                       input logic st, input logic [4:0] rd, input logic [63:0] dword,
                       input int ready_low, input int rdelay, input bit bresp,
                       input logic [63:0] e_rdata, input logic e_err, input int e_nreq,
                       input int e_lat, input logic [63:0] e_data, input logic [7:0] e_mask);
    exp_t e;
    int   nreq, req_cyc, lat;
    bit   seen;
    e.rdata = e_rdata; e.err = e_err; e.rd = st ? 5'd0 : rd;
    sb.push_back(e);
    @(negedge I_clk);
    chk("ready_before", {63'b0, O_ready}, 64'd1);
    I_valid = 1'b1; I_addr = addr; I_wdata = wdata; I_funct3 = f3; I_is_store = st; I_rd = rd;
    I_cpu_mem_ready = (ready_low == 0);
    @(posedge I_clk);
    #1 I_valid = 1'b0;
    nreq = 0; seen = 0; lat = -1; req_cyc = 0;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge I_clk);
      I_cpu_mem_ready = (cyc > ready_low);
      I_cpu_rvalid    = seen && !st && rdelay >= 0 && cyc == req_cyc + rdelay;
      I_cpu_data      = I_cpu_rvalid ? dword : 64'h0;
      I_cpu_bvalid    = seen && st && bresp && cyc == req_cyc + 1;
      #1;
      if (O_valid) lat = cyc;
      if (O_cpu_rd_req || O_cpu_wr_req) begin
        nreq++;
        if (!seen) begin
          seen = 1; req_cyc = cyc;
          chk("req_kind", {63'b0, O_cpu_wr_req}, {63'b0, st});
          chk("req_addr", {32'b0, O_cpu_addr}, {32'b0, addr});
          if (st) begin
            chk("req_data", O_cpu_data, e_data);
            chk("req_mask", {56'b0, O_cpu_wmask}, {56'b0, e_mask});
          end
        end
      end
    end
    I_cpu_rvalid = 1'b0; I_cpu_bvalid = 1'b0; I_cpu_data = 64'h0;
    if (lat < 0) begin
      chk("valid_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    chk("nreq", 64'(nreq), 64'(e_nreq));
    if (e_lat >= 0) chk("latency", 64'(lat), 64'(e_lat));
    else            chk("latency_err", {63'b0, (lat >= 1 && lat <= 2)}, 64'd1);
    @(negedge I_clk);
    chk("valid_pulse", {63'b0, O_valid}, 64'd0);
    chk("ready_after", {63'b0, O_ready}, 64'd1);
  endtask

  initial begin
    I_rst = 1'b1; I_valid = 1'b0; I_addr = '0; I_wdata = '0; I_funct3 = '0;
    I_is_store = 1'b0; I_rd = '0; I_cpu_mem_ready = 1'b0; I_cpu_data = '0;
    I_cpu_rvalid = 1'b0; I_cpu_bvalid = 1'b0;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    chk("rst_ready", {63'b0, O_ready}, 64'd1);
    chk("rst_valid", {63'b0, O_valid}, 64'd0);
    chk("rst_rdata", O_rdata, 64'd0);
    chk("rst_req",   {62'b0, O_cpu_rd_req, O_cpu_wr_req}, 64'd0);
    chk("rst_mask",  {56'b0, O_cpu_wmask}, 64'd0);
    I_rst = 1'b0;

    //     addr          wdata                  f3    st  rd  dword                  rl  rdly b  e_rdata                e_err n  lat e_data                 e_mask
    do_op(32'h80000010, 64'h0,                 3'b011, 0, 5,  64'h1122334455667788, 0,  1,   0, 64'h1122334455667788, 0,    1, 3,  64'h0, 8'h00);
    do_op(32'h80000007, 64'h0,                 3'b000, 0, 6,  64'h80AA000000000000, 0,  1,   0, 64'hFFFFFFFFFFFFFF80, 0,    1, 3,  64'h0, 8'h00);
    do_op(32'h80000007, 64'h0,                 3'b100, 0, 7,  64'h80AA000000000000, 0,  1,   0, 64'h0000000000000080, 0,    1, 3,  64'h0, 8'h00);
    do_op(32'h80000006, 64'h0,                 3'b001, 0, 8,  64'h80AA000000000000, 0,  3,   0, 64'hFFFFFFFFFFFF80AA, 0,    1, 5,  64'h0, 8'h00);
    do_op(32'h80000006, 64'h0,                 3'b101, 0, 9,  64'h80AA000000000000, 2,  1,   0, 64'h00000000000080AA, 0,    1, 5,  64'h0, 8'h00);
    do_op(32'h80000004, 64'h0,                 3'b010, 0, 10, 64'h8765432100000000, 0,  1,   0, 64'hFFFFFFFF87654321, 0,    1, 3,  64'h0, 8'h00);
    do_op(32'h80000004, 64'h0,                 3'b110, 0, 11, 64'h8765432100000000, 0,  1,   0, 64'h0000000087654321, 0,    1, 3,  64'h0, 8'h00);
    do_op(32'h80000000, 64'h0,                 3'b010, 0, 12, 64'hFFFFFFFF7FFFFFFF, 0,  1,   0, 64'h000000007FFFFFFF, 0,    1, 3,  64'h0, 8'h00);
    // stores: hit with bvalid, byte/double lanes, MMIO write with no bvalid
    do_op(32'h80000002, 64'hBEEF,              3'b001, 1, 13, 64'h0,                0,  1,   1, 64'h0,                0,    1, 3,  64'h00000000BEEF0000, 8'h0C);
    do_op(32'h80000005, 64'hAB,                3'b000, 1, 14, 64'h0,                0,  1,   1, 64'h0,                0,    1, 3,  64'h0000AB0000000000, 8'h20);
    do_op(32'h80000008, 64'hDEADBEEFCAFEF00D,  3'b011, 1, 15, 64'h0,                0,  1,   0, 64'h0,                0,    1, 3,  64'hDEADBEEFCAFEF00D, 8'hFF);
    do_op(32'hA00003F8, 64'h12345678,          3'b010, 1, 16, 64'h0,                5,  1,   0, 64'h0,                0,    1, 8,  64'h0000000012345678, 8'h0F);
    // misaligned and illegal encodings: error beat, no dcache request
    do_op(32'h80000002, 64'h0,                 3'b010, 0, 17, 64'h0,                0,  1,   0, 64'h0,                1,    0, -1, 64'h0, 8'h00);
    do_op(32'h80000004, 64'h0,                 3'b011, 0, 18, 64'h0,                0,  1,   0, 64'h0,                1,    0, -1, 64'h0, 8'h00);
    do_op(32'h80000001, 64'h0,                 3'b001, 1, 19, 64'h0,                0,  1,   0, 64'h0,                1,    0, -1, 64'h0, 8'h00);
    do_op(32'h80000000, 64'h0,                 3'b111, 0, 20, 64'h0,                0,  1,   0, 64'h0,                1,    0, -1, 64'h0, 8'h00);
    do_op(32'h80000000, 64'h0,                 3'b100, 1, 21, 64'h0,                0,  1,   0, 64'h0,                1,    0, -1, 64'h0, 8'h00);
    // timeouts with WAIT_LIMIT=16: no rvalid, ready never high, rvalid exactly at the limit
    do_op(32'h80000020, 64'h0,                 3'b011, 0, 22, 64'h0,                0,  -1,  0, 64'h0,                1,    1, 17, 64'h0, 8'h00);
    do_op(32'h80000020, 64'h0,                 3'b011, 0, 23, 64'h0,                99, -1,  0, 64'h0,                1,    0, 17, 64'h0, 8'h00);
    do_op(32'h80000028, 64'h0,                 3'b011, 0, 24, 64'h0123456789ABCDEF, 0,  15,  0, 64'h0123456789ABCDEF, 0,    1, 17, 64'h0, 8'h00);

    // reset while waiting for read data drops the op with no result beat
    @(negedge I_clk);
    I_valid = 1'b1; I_addr = 32'h80000040; I_funct3 = 3'b011; I_is_store = 1'b0; I_rd = 5'd25;
    I_cpu_mem_ready = 1'b1;
    @(posedge I_clk);
    #1 I_valid = 1'b0;
    repeat (3) @(negedge I_clk);
    I_rst = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    chk("midrst_ready", {63'b0, O_ready}, 64'd1);
    chk("midrst_valid", {63'b0, O_valid}, 64'd0);
    I_rst = 1'b0;
    repeat (20) @(negedge I_clk);
    chk("midrst_idle", {63'b0, O_ready}, 64'd1);

    do_op(32'h80000010, 64'h0,                 3'b011, 0, 26, 64'hCAFEBABE00000001, 0,  1,   0, 64'hCAFEBABE00000001, 0,    1, 3,  64'h0, 8'h00);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stall exp=finish");
    $fatal(1);
  end

endmodule
